// File: rtl/jtag_host_pkg.sv
// jtag_host_pkg: shared state encodings and constants for the JTAG host.
// JTAG_HOST_AUTO_RESET_EN adds the TRST states used for the post-reset TAP reset sequence.
package jtag_host_pkg;
    localparam int TRST_PULSES = 5;
    localparam int LEN_W = 6;
    localparam int HALF_MIN = 8;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
`ifdef JTAG_HOST_AUTO_RESET_EN
        , ST_TRST_LOW,
        ST_TRST_HIGH
`endif
    } state_t;
endpackage

// File: rtl/jtag_host_sync.sv
// jtag_host_sync: two-flop synchronizer for the asynchronous TDO pin.
module jtag_host_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk) begin
        if (rst) begin
            m <= 1'b0;
            q <= 1'b0;
        end else begin
            m <= d;
            q <= m;
        end
    end
endmodule

// File: rtl/jtag_host.sv
// jtag_host: clocks up to WIDTH bits of TMS/TDI out to a JTAG target and captures TDO.
// Define JTAG_HOST_AUTO_RESET_EN to issue five TMS=1 TCK pulses after every reset.
module jtag_host
    import jtag_host_pkg::*;
#(
    parameter int HALF_PERIOD = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [LEN_W-1:0] cmdLen,
    input  logic [WIDTH-1:0] cmdTms,
    input  logic [WIDTH-1:0] cmdTdi,
    output logic             rspValid,
    output logic [WIDTH-1:0] rspTdo,
    output logic             jtagTCK,
    output logic             jtagTMS,
    output logic             jtagTDI,
    input  logic             jtagTDO
);
    localparam int HP = HALF_PERIOD < HALF_MIN ? HALF_MIN : HALF_PERIOD;
    localparam logic [7:0] HLAST = 8'(HP - 1);
    localparam logic [LEN_W-1:0] WMAX = LEN_W'(WIDTH);
`ifdef JTAG_HOST_AUTO_RESET_EN
    localparam state_t RST_ST = ST_TRST_LOW;
`else
    localparam state_t RST_ST = ST_IDLE;
`endif

    state_t state, state_n;
    logic [7:0] cnt;
    logic [LEN_W-1:0] idx, len, eff_len;
    logic [WIDTH-1:0] tms_sh, tdi_sh, tdo_r;
    logic tdo_s, accept, phase_end, last_bit;

    jtag_host_sync u_sync (.clk(clk), .rst(rst), .d(jtagTDO), .q(tdo_s));

    assign cmdReady = state == ST_IDLE;
    assign accept = cmdValid && cmdReady;
    assign eff_len = cmdLen > WMAX ? WMAX : cmdLen;
    assign phase_end = cnt == HLAST;
    assign last_bit = idx == len - LEN_W'(1);
    assign rspValid = state == ST_DONE;
    assign rspTdo = tdo_r;
    // The shift registers' bit 0 is the live pin value and also holds it between commands.
    assign jtagTMS = tms_sh[0];
    assign jtagTDI = tdi_sh[0];
`ifdef JTAG_HOST_AUTO_RESET_EN
    assign jtagTCK = state == ST_HIGH || state == ST_TRST_HIGH;
`else
    assign jtagTCK = state == ST_HIGH;
`endif

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:      if (accept) state_n = eff_len == '0 ? ST_DONE : ST_LOW;
            ST_LOW:       if (phase_end) state_n = ST_HIGH;
            ST_HIGH:      if (phase_end) state_n = last_bit ? ST_DONE : ST_LOW;
`ifdef JTAG_HOST_AUTO_RESET_EN
            ST_TRST_LOW:  if (phase_end) state_n = ST_TRST_HIGH;
            ST_TRST_HIGH: if (phase_end) state_n = idx == LEN_W'(TRST_PULSES - 1) ? ST_IDLE : ST_TRST_LOW;
`endif
            default:      state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_ST;
            cnt <= '0;
            idx <= '0;
            len <= '0;
            tms_sh <= WIDTH'(1);
            tdi_sh <= '0;
            tdo_r <= '0;
        end else begin
            state <= state_n;
            cnt <= state_n != state ? '0 : cnt + 8'd1;
            if (accept) begin
                len <= eff_len;
                idx <= '0;
                tdo_r <= '0;
                if (eff_len != '0) begin
                    tms_sh <= cmdTms;
                    tdi_sh <= cmdTdi;
                end
            end
            if (state == ST_LOW && phase_end)
                tdo_r <= tdo_r | (WIDTH'(tdo_s) << idx);
            if (state == ST_HIGH && phase_end && !last_bit) begin
                idx <= idx + LEN_W'(1);
                tms_sh <= tms_sh >> 1;
                tdi_sh <= tdi_sh >> 1;
            end
`ifdef JTAG_HOST_AUTO_RESET_EN
            if (state == ST_TRST_HIGH && phase_end)
                idx <= idx == LEN_W'(TRST_PULSES - 1) ? '0 : idx + LEN_W'(1);
`endif
        end
    end
endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: randomized self-checking bench for jtag_host with an in-bench JTAG target model.
module tb_jtag_host;
    localparam int H = 8;
    localparam int W = 32;

    logic clk = 1'b0, rst = 1'b1, cmdValid = 1'b0, jtagTDO = 1'b0;
    logic [5:0] cmdLen = '0;
    logic [W-1:0] cmdTms = '0, cmdTdi = '0;
    logic cmdReady, rspValid, jtagTCK, jtagTMS, jtagTDI;
    logic [W-1:0] rspTdo;
    int checks = 0, failures = 0;
    logic idle_tms = 1'b1, idle_tdi = 1'b0;
`ifdef JTAG_HOST_AUTO_RESET_EN
    localparam logic READY_AFTER_RST = 1'b0;
`else
    localparam logic READY_AFTER_RST = 1'b1;
`endif

    jtag_host #(.HALF_PERIOD(H), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdLen(cmdLen),
        .cmdTms(cmdTms), .cmdTdi(cmdTdi), .rspValid(rspValid), .rspTdo(rspTdo),
        .jtagTCK(jtagTCK), .jtagTMS(jtagTMS), .jtagTDI(jtagTDI), .jtagTDO(jtagTDO)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({jtagTCK, jtagTMS, jtagTDI, cmdReady, rspValid} !== {1'b0, 1'b1, 1'b0, READY_AFTER_RST, 1'b0} || rspTdo !== '0) begin
            failures++;
            $display("FAIL reset pins tck/tms/tdi/ready/valid=%b%b%b%b%b tdo=%h expected 010%b0 tdo=0",
                     jtagTCK, jtagTMS, jtagTDI, cmdReady, rspValid, rspTdo, READY_AFTER_RST);
        end
        rst = 1'b0;
        idle_tms = 1'b1;
        idle_tdi = 1'b0;
    endtask

    // Waits for the host to go idle; reaching the bound counts as a failure.
    task automatic wait_ready();
        int n = 0;
        while (!cmdReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!cmdReady) begin
            failures++;
            $display("FAIL wait_ready cmdReady=%b after %0d cycles, expected 1", cmdReady, n);
        end
    endtask

`ifdef JTAG_HOST_AUTO_RESET_EN
    task automatic test_trst();
        int rises = 0, first_ready = -1, pulses = 0;
        logic prev = 1'b0, bad_pins = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) @(negedge clk);
            if (jtagTCK && !prev) begin
                rises++;
                if (jtagTMS !== 1'b1 || jtagTDI !== 1'b0) bad_pins = 1'b1;
            end
            prev = jtagTCK;
            if (rspValid) pulses++;
            if (cmdReady && first_ready < 0) first_ready = c;
        end
        checks++;
        if (rises != 5 || bad_pins || pulses != 0 || first_ready != 81) begin
            failures++;
            $display("FAIL trst rises=%0d bad_pins=%b rsp=%0d ready_cycle=%0d expected 5 0 0 81",
                     rises, bad_pins, pulses, first_ready);
        end
    endtask
`endif

    // Runs one command against a target that shifts tdo[k] out after each falling TCK edge.
    task automatic run_cmd(input string name, input int len, input logic [63:0] tms, input logic [63:0] tdi, input logic [63:0] tdo);
        int eff = len > W ? W : len;
        logic [63:0] mask = (64'd1 << eff) - 64'd1;
        int k = 0, rises = 0, done_c = -1;
        logic prev = 1'b0;
        logic [63:0] seen_tms = '0, seen_tdi = '0, got = '0;
        @(negedge clk);
        cmdLen = 6'(len);
        cmdTms = tms[W-1:0];
        cmdTdi = tdi[W-1:0];
        jtagTDO = tdo[0];
        cmdValid = 1'b1;
        checks++;
        if (cmdReady !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_at_offer got %b expected 1", name, cmdReady);
        end
        for (int c = 1; c <= 2 * H * W + 10 && done_c < 0; c++) begin
            @(negedge clk);
            cmdValid = 1'b0;
            if (jtagTCK && !prev) begin
                seen_tms[rises] = jtagTMS;
                seen_tdi[rises] = jtagTDI;
                rises++;
            end
            if (!jtagTCK && prev) begin
                k++;
                jtagTDO = tdo[k];
            end
            prev = jtagTCK;
            if (rspValid) begin
                done_c = c;
                got = {32'b0, rspTdo};
            end
        end
        checks++;
        if (done_c != 2 * H * eff + 1) begin
            failures++;
            $display("FAIL %s latency got cycle %0d expected %0d", name, done_c, 2 * H * eff + 1);
        end
        checks++;
        if (rises != eff) begin
            failures++;
            $display("FAIL %s tck_rises got %0d expected %0d", name, rises, eff);
        end
        checks++;
        if (seen_tms !== (tms & mask) || seen_tdi !== (tdi & mask)) begin
            failures++;
            $display("FAIL %s pins tms=%h tdi=%h expected tms=%h tdi=%h", name, seen_tms, seen_tdi, tms & mask, tdi & mask);
        end
        checks++;
        if (got !== (tdo & mask)) begin
            failures++;
            $display("FAIL %s rspTdo got %h expected %h", name, got, tdo & mask);
        end
        if (eff > 0) begin
            idle_tms = tms[eff-1];
            idle_tdi = tdi[eff-1];
        end
        @(negedge clk);
        checks++;
        if (rspValid !== 1'b0 || cmdReady !== 1'b1 || {32'b0, rspTdo} !== (tdo & mask) || jtagTCK !== 1'b0 ||
            jtagTMS !== idle_tms || jtagTDI !== idle_tdi) begin
            failures++;
            $display("FAIL %s after_done valid=%b ready=%b tdo=%h tck=%b tms=%b tdi=%b expected 0 1 %h 0 %b %b",
                     name, rspValid, cmdReady, rspTdo, jtagTCK, jtagTMS, jtagTDI, tdo & mask, idle_tms, idle_tdi);
        end
    endtask

    task automatic test_directed();
        run_cmd("len4", 4, 64'h0, 64'hA, 64'h6);
        run_cmd("len0", 0, 64'hFFFF, 64'hFFFF, 64'hFFFF_FFFF);
        run_cmd("len40", 40, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        run_cmd("len32", 32, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        run_cmd("len1", 1, 64'h1, 64'h1, 64'h1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++)
            run_cmd("random", int'($urandom_range(0, 40)), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic test_back_to_back();
        int first_ready = -1, rsp1 = -1, rsp2 = -1;
        logic [W-1:0] tdi = W'($urandom), tms = W'($urandom);
        @(negedge clk);
        cmdLen = 6'd8;
        cmdTdi = tdi;
        cmdTms = tms;
        cmdValid = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (first_ready >= 0) cmdValid = 1'b0;
            if (rspValid) begin
                if (rsp1 < 0) rsp1 = c;
                else if (rsp2 < 0) rsp2 = c;
            end
            if (cmdReady && first_ready < 0) first_ready = c;
        end
        checks++;
        if (first_ready != 130 || rsp1 != 129 || rsp2 != 259) begin
            failures++;
            $display("FAIL back_to_back ready=%0d rsp1=%0d rsp2=%0d expected 130 129 259", first_ready, rsp1, rsp2);
        end
        idle_tms = tms[7];
        idle_tdi = tdi[7];
    endtask

    task automatic test_mid_reset();
        int pulses = 0;
        @(negedge clk);
        cmdLen = 6'd8;
        cmdTms = W'($urandom) & ~W'(1);
        cmdTdi = W'($urandom) | W'(1);
        cmdValid = 1'b1;
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk);
            cmdValid = 1'b0;
        end
        checks++;
        if (jtagTCK !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset tck_before got %b expected 1", jtagTCK);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (jtagTCK !== 1'b0 || jtagTMS !== 1'b1 || jtagTDI !== 1'b0 || rspValid !== 1'b0 || cmdReady !== READY_AFTER_RST) begin
            failures++;
            $display("FAIL mid_reset pins tck=%b tms=%b tdi=%b valid=%b ready=%b expected 0 1 0 0 %b",
                     jtagTCK, jtagTMS, jtagTDI, rspValid, cmdReady, READY_AFTER_RST);
        end
        rst = 1'b0;
        idle_tms = 1'b1;
        idle_tdi = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (rspValid) pulses++;
        end
        checks++;
        if (pulses != 0 || cmdReady !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset aftermath rsp=%0d ready=%b expected 0 1", pulses, cmdReady);
        end
    endtask

    initial begin
        test_reset();
`ifdef JTAG_HOST_AUTO_RESET_EN
        test_trst();
`endif
        wait_ready();
        test_directed();
        test_random();
        test_back_to_back();
        wait_ready();
        test_mid_reset();
        wait_ready();
        run_cmd("after_reset", 5, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtag_host.md
JTAG_HOST -- requirements
Module: jtag_host

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 8, clk cycles per TCK half-period (legal 8..255).
REQ-002 SHALL have parameter WIDTH, default 32, max bits per command (legal 1..32).
REQ-003 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have cmdValid  input  1  command offered.
REQ-006 SHALL have cmdReady  output  1  host idle, command accepted when cmdValid&&cmdReady.
REQ-007 SHALL have cmdLen  input  6  bits to clock (0..63).
REQ-008 SHALL have cmdTms  input  WIDTH  TMS per bit, bit 0 first.
REQ-009 SHALL have cmdTdi  input  WIDTH  TDI per bit, bit 0 first.
REQ-010 SHALL have rspValid  output  1  one-cycle pulse, rspTdo valid.
REQ-011 SHALL have rspTdo  output  WIDTH  captured TDO, bit i = bit i of command.
REQ-012 SHALL have jtagTCK, jtagTMS, jtagTDI  output  1 each  JTAG pins to target.
REQ-013 SHALL have jtagTDO  input  1  asynchronous JTAG TDO from target.

Function
REQ-014 SHALL implement FSM IDLE, LOW, HIGH, DONE (plus TRST, see Configuration).
REQ-015 IDLE: cmdReady=1, jtagTCK=0; on accept latch cmdTms/cmdTdi/effective length, bit index=0, go LOW.
REQ-016 Effective length SHALL be min(cmdLen, WIDTH); cmdLen=0 SHALL go IDLE->DONE directly, no TCK edge, rspTdo=0.
REQ-017 LOW: jtagTCK=0, jtagTMS/jtagTDI = latched bit[index], held HALF_PERIOD cycles; last LOW cycle samples synchronized TDO into rspTdo[index]; then HIGH.
REQ-018 HIGH: jtagTCK=1 for HALF_PERIOD cycles, TMS/TDI held; then DONE if index==length-1, else index+1 and LOW.
REQ-019 DONE: rspValid=1 exactly one cycle, jtagTCK=0; next cycle IDLE.
REQ-020 Latency: accept at cycle 0 -> rspValid at cycle 2*HALF_PERIOD*length+1; cmdReady high again one cycle later.
REQ-021 cmdReady SHALL be 0 outside IDLE; cmdValid then ignored, no queueing.
REQ-022 rspValid has no backpressure; rspTdo SHALL hold until next accept; bits >= length SHALL read 0.
REQ-023 Between commands jtagTMS/jtagTDI SHALL hold last driven values, jtagTCK=0.
REQ-024 jtagTDO SHALL pass a two-flop synchronizer before sampling.

Reset
REQ-025 rst SHALL force, next edge: state IDLE (or TRST), jtagTCK=0, jtagTMS=1, jtagTDI=0, rspValid=0, rspTdo=0, index=0.
REQ-026 rst mid-command SHALL abort with no rspValid; rst has priority over every transition.

Configuration
REQ-027 Macro JTAG_HOST_AUTO_RESET_EN defined: after rst release, state TRST issues 5 TCK pulses with TMS=1, TDI=0, same LOW/HIGH timing, cmdReady=0, no rspValid, then IDLE.
REQ-028 Macro undefined: no TRST state; reset goes straight to IDLE.

Structure
REQ-029 Shared package jtag_host_pkg SHALL hold state encodings, TRST pulse count (5), cmdLen width (6), HALF_PERIOD minimum (8).
REQ-030 Sub-module jtag_host_sync (two-flop synchronizer) SHALL be used for jtagTDO; no other sub-modules.

Verification
REQ-031 rst 3 cycles, macro off -> TCK=0, TMS=1, TDI=0, cmdReady=1, rspValid=0, rspTdo=0.
REQ-032 cmdLen=4, cmdTdi=0xA, cmdTms=0, target model drives TDO 0,1,1,0 -> TDI 0,1,0,1, 4 rising TCK edges, rspTdo=0x6, rspValid at cycle 65.
REQ-033 cmdLen=0 -> rspValid at cycle 1, no TCK edge, rspTdo=0; cmdLen=40 -> exactly 32 pulses, rspValid at cycle 513.
REQ-034 cmdValid held high during 8-bit command -> only one accept; second accept at cycle 130.
REQ-035 rst during HIGH of bit 2 of 8-bit command -> next cycle TCK=0, TMS=1, no rspValid, cmdReady=1.
REQ-036 Macro on: rst release -> 5 TCK pulses, TMS=1, cmdReady=0 until cycle 81, then 1.
